fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage pipeline: owns the program counter, drives the chip-enable and address of the combinational instruction memory, and registers the returned word plus its PC into the IF/ID pipeline register. It takes branch redirects from ID, pipeline flushes from the exception/control logic, and stall requests from the stall controller. Downstream consumer is the ID stage.

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit_if_id_reg.sv | 45 ++++
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, control encodings, FSM states.
package fetch_unit_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic                   RST_ENABLE   = 1'b0;
  localparam logic                   CHIP_ENABLE  = 1'b1;
  localparam logic                   CHIP_DISABLE = 1'b0;
  localparam logic [INST_W-1:0]      ZERO_WORD    = INST_W'(0);
  localparam logic [INST_ADDR_W-1:0] PC_STEP      = INST_ADDR_W'(4);

  typedef enum logic {
    RESET_WAIT = 1'b0,
    FETCH      = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
    logic                   valid;
  } if_id_t;

  // Redirect targets are always forced onto a word boundary.
  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush/stall/bubble handling and accepted-instruction counter.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   stall_id,
  input  logic                   stall_if,
  input  logic [INST_ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0]      if_inst,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_valid,
  output logic [31:0]            fetch_count
);

  localparam if_id_t BUBBLE = '{pc: INST_ADDR_W'(0), inst: ZERO_WORD, valid: 1'b0};

  if_id_t stage_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      stage_q     <= BUBBLE;
      fetch_count <= 32'(0);
    end else if (en) begin
      if (flush) begin
        stage_q <= BUBBLE;
      end else if (!stall_id) begin
        if (stall_if) begin
          stage_q <= BUBBLE;
        end else begin
          stage_q     <= '{pc: if_pc, inst: if_inst, valid: 1'b1};
          fetch_count <= fetch_count + 32'(1);
        end
      end
    end
  end

  assign id_pc    = stage_q.pc;
  assign id_inst  = stage_q.inst;
  assign id_valid = stage_q.valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC and reset-wait FSM, instruction-memory interface, IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_if,
  input  logic                   stall_id,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  input  logic                   flush_i,
  input  logic [INST_ADDR_W-1:0] new_pc_i,
  input  logic [INST_W-1:0]      inst_i,
  output logic                   ce_o,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o,
  output logic                   id_valid_o,
  output logic [31:0]            fetch_count_o
);

  fetch_state_e           state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_d;
  logic                   fetching;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q <= RESET_WAIT;
      pc_o    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_o    <= pc_d;
    end
  end

  // A stall_id without stall_if is treated as a PC hold as well.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_o;
    case (state_q)
      RESET_WAIT: state_d = FETCH;
      FETCH: begin
        if (flush_i)                  pc_d = word_align(new_pc_i);
        else if (stall_if || stall_id) pc_d = pc_o;
        else if (branch_flag_i)        pc_d = word_align(branch_target_i);
        else                           pc_d = pc_o + PC_STEP;
      end
      default: state_d = RESET_WAIT;
    endcase
  end

  assign fetching = (state_q == FETCH);
  assign ce_o     = fetching ? CHIP_ENABLE : CHIP_DISABLE;

  fetch_unit_if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .en          (fetching),
    .flush       (flush_i),
    .stall_id    (stall_id),
    .stall_if    (stall_if),
    .if_pc       (pc_o),
    .if_inst     (inst_i),
    .id_pc       (id_pc_o),
    .id_inst     (id_inst_o),
    .id_valid    (id_valid_o),
    .fetch_count (fetch_count_o)
  );

  always @(posedge clk) begin
    if (rst != RST_ENABLE && fetching) begin
      assert (!(stall_id && !stall_if))
        else $error("stall protocol violation: stall_id without stall_if");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus reset-wait and async-reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, stall_id, branch_flag_i, flush_i;
  logic [31:0] branch_target_i, new_pc_i, inst_i;
  logic        ce_o, id_valid_o;
  logic [31:0] pc_o, id_pc_o, id_inst_o, fetch_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word at address A holds (A/4)+1.
  assign inst_i = ce_o ? ((pc_o >> 2) + 32'd1) : 32'd0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .inst_i          (inst_i),
    .ce_o            (ce_o),
    .pc_o            (pc_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_valid_o      (id_valid_o),
    .fetch_count_o   (fetch_count_o)
  );

  typedef struct {
    logic        si, sid, br, fl;
    logic [31:0] tgt, npc;
    logic [31:0] e_pc, e_id_pc, e_id_inst, e_cnt;
    logic        e_valid;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic si, input logic sid, input logic br,
                              input logic [31:0] tgt, input logic fl, input logic [31:0] npc,
                              input logic [31:0] e_pc, input logic [31:0] e_id_pc,
                              input logic [31:0] e_id_inst, input logic e_valid,
                              input logic [31:0] e_cnt);
    vec_t v;
    v.si = si; v.sid = sid; v.br = br; v.tgt = tgt; v.fl = fl; v.npc = npc;
    v.e_pc = e_pc; v.e_id_pc = e_id_pc; v.e_id_inst = e_id_inst;
    v.e_valid = e_valid; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_ce, input logic [31:0] e_pc,
                           input logic [31:0] e_id_pc, input logic [31:0] e_id_inst,
                           input logic e_valid, input logic [31:0] e_cnt);
    check({tag, ".ce"},      32'(ce_o),       32'(e_ce));
    check({tag, ".pc"},      pc_o,            e_pc);
    check({tag, ".id_pc"},   id_pc_o,         e_id_pc);
    check({tag, ".id_inst"}, id_inst_o,       e_id_inst);
    check({tag, ".valid"},   32'(id_valid_o), 32'(e_valid));
    check({tag, ".count"},   fetch_count_o,   e_cnt);
  endtask

  task automatic idle_inputs();
    stall_if = 0; stall_id = 0; branch_flag_i = 0; flush_i = 0;
    branch_target_i = 32'd0; new_pc_i = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           si sid br tgt           fl npc           pc            id_pc         id_inst       v  cnt
    vecs[0]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h0,        32'h1,        1, 32'd1);
    vecs[1]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'h4,        32'h2,        1, 32'd2);
    vecs[2]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'h0,        32'h0,        0, 32'd2);
    vecs[3]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'h0,        32'h0,        0, 32'd2);
    vecs[4]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'hC,        32'h8,        32'h3,        1, 32'd3);
    vecs[5]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        32'hC,        32'h8,        32'h3,        1, 32'd3);
    vecs[6]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        32'hC,        32'h8,        32'h3,        1, 32'd3);
    vecs[7]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        32'hC,        32'h8,        32'h3,        1, 32'd3);
    vecs[8]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h10,       32'hC,        32'h4,        1, 32'd4);
    vecs[9]  = mk(0, 0, 1, 32'h102,      0, 32'h0,        32'h100,      32'h10,       32'h5,        1, 32'd5);
    vecs[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h104,      32'h100,      32'h41,       1, 32'd6);
    vecs[11] = mk(0, 0, 1, 32'h200,      1, 32'h182,      32'h180,      32'h0,        32'h0,        0, 32'd6);
    vecs[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h184,      32'h180,      32'h61,       1, 32'd7);
    vecs[13] = mk(1, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,       32'h0,        0, 32'd7);
    vecs[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h4000_0000, 1, 32'd8);
    vecs[15] = mk(1, 0, 1, 32'h40,       0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'd8);
    vecs[16] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h0,        32'h1,        1, 32'd9);

    idle_inputs();
    rst = 1'b0;
    #2;
    check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    step();
    check_all("reset_wait", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      stall_if = vecs[i].si; stall_id = vecs[i].sid;
      branch_flag_i = vecs[i].br; branch_target_i = vecs[i].tgt;
      flush_i = vecs[i].fl; new_pc_i = vecs[i].npc;
      step();
      check_all($sformatf("vec%0d", i), 1'b1, vecs[i].e_pc, vecs[i].e_id_pc,
                vecs[i].e_id_inst, vecs[i].e_valid, vecs[i].e_cnt);
    end

    // Advance a few words so the asynchronous reset has state to clear.
    @(negedge clk);
    idle_inputs();
    step();
    step();
    check_all("pre_rst", 1'b1, 32'hC, 32'h8, 32'h3, 1'b1, 32'd11);

    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    step();
    check_all("rewait", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    step();
    check_all("refetch", 1'b1, 32'h4, 32'h0, 32'h1, 1'b1, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
